// File: rtl/exc_sequencer.sv
// rtl/exc_sequencer.sv - M-stage exception/interrupt/eret sequencer beside CP0
//
// Synchronizes the raw device interrupt lines into CP0 HWInt, selects at most
// one event per cycle (interrupt > exception > eret), drives the CP0 update
// inputs, then holds a fixed-length pipeline flush with a single PC redirect.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   hw_irq[5:0]         raw asynchronous device interrupt lines
//   m_valid/m_pc/m_bd   M-stage instruction valid, PC, delay-slot flag
//   m_exc/m_exc_code    M-stage exception flag and ExcCode
//   m_eret              M-stage instruction is eret
//   cp0_int_req         CP0 IntReq (already masked)
//   cp0_epc             CP0 EPC
//   hwint[5:0]          synchronized interrupt lines to CP0 HWInt
//   exl_set/exl_clr     CP0 EXLSet / EXLClr
//   exc_code/exc_pc/exc_bd  CP0 ExcCode / PC / BD inputs
//   flush               kill F/D/E/M pipeline registers
//   redirect/redirect_pc    load redirect_pc into the PC
//   busy                sequencer is flushing
module exc_sequencer #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  hw_irq,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic        m_exc,
    input  logic [4:0]  m_exc_code,
    input  logic        m_eret,
    input  logic        cp0_int_req,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  hwint,
    output logic        exl_set,
    output logic        exl_clr,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_pc,
    output logic        exc_bd,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [5:0] sync1_q;
    logic [5:0] sync2_q;

    logic idle;
    logic take_irq;
    logic take_exc;
    logic take_eret;
    logic take;

    // Reset gates the take decision so a reset cycle never produces take outputs.
    assign idle      = (state_q == S_IDLE) && !reset;
    assign take_irq  = idle && m_valid && cp0_int_req;
    // A simultaneous interrupt wins; the excepting instruction is flushed and re-executes later.
    assign take_exc  = idle && m_valid && m_exc && !cp0_int_req;
    assign take_eret = idle && m_valid && m_eret && !m_exc && !cp0_int_req;
    assign take      = take_irq || take_exc || take_eret;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            sync1_q <= 6'd0;
            sync2_q <= 6'd0;
        end else begin
            sync1_q <= hw_irq;
            sync2_q <= sync1_q;
            case (state_q)
                S_IDLE: begin
                    if (take) begin
                        state_q <= S_FLUSH;
                        cnt_q   <= FLUSH_LOAD;
                    end
                end
                S_FLUSH: begin
                    // The cycle that sees a count of 1 is the last flushing cycle.
                    if (cnt_q <= 4'd1) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    assign hwint = sync2_q;

    always_comb begin
        exl_set     = 1'b0;
        exl_clr     = 1'b0;
        exc_code    = 5'd0;
        exc_pc      = 32'd0;
        exc_bd      = 1'b0;
        redirect    = take;
        redirect_pc = HANDLER_ADDR;
        busy        = (state_q == S_FLUSH) && !reset;
        flush       = take || busy;

        if (take_irq || take_exc) begin
            exc_pc = m_pc;
            exc_bd = m_bd;
        end
        if (take_exc) begin
            exl_set  = 1'b1;
            exc_code = m_exc_code;
        end
        if (take_eret) begin
            exl_clr     = 1'b1;
            redirect_pc = cp0_epc;
        end
    end

endmodule

// File: tb/tb_exc_sequencer.sv
// tb/tb_exc_sequencer.sv - self-checking bench for exc_sequencer
module tb_exc_sequencer;

    localparam logic [31:0] HANDLER = 32'h0000_4180;
    localparam int          FC      = 2;

    logic        clk;
    logic        reset;
    logic [5:0]  hw_irq;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_bd;
    logic        m_exc;
    logic [4:0]  m_exc_code;
    logic        m_eret;
    logic        cp0_int_req;
    logic [31:0] cp0_epc;
    logic [5:0]  hwint;
    logic        exl_set;
    logic        exl_clr;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    exc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .hw_irq     (hw_irq),
        .m_valid    (m_valid),
        .m_pc       (m_pc),
        .m_bd       (m_bd),
        .m_exc      (m_exc),
        .m_exc_code (m_exc_code),
        .m_eret     (m_eret),
        .cp0_int_req(cp0_int_req),
        .cp0_epc    (cp0_epc),
        .hwint      (hwint),
        .exl_set    (exl_set),
        .exl_clr    (exl_clr),
        .exc_code   (exc_code),
        .exc_pc     (exc_pc),
        .exc_bd     (exc_bd),
        .flush      (flush),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Behavioural model: remaining flush cycles after a take, and the hw_irq
    // values seen at the last two rising edges.
    int         rem = 0;
    logic [5:0] seen_last = 6'd0;
    logic [5:0] seen_prev = 6'd0;

    function automatic logic ev_irq();
        return m_valid && cp0_int_req;
    endfunction
    function automatic logic ev_exc();
        return m_valid && m_exc;
    endfunction
    function automatic logic ev_eret();
        return m_valid && m_eret && !m_exc;
    endfunction
    function automatic logic model_take();
        return !reset && rem == 0 && (ev_irq() || ev_exc() || ev_eret());
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            rem       = 0;
            seen_last = 6'd0;
            seen_prev = 6'd0;
        end else begin
            seen_prev = seen_last;
            seen_last = hw_irq;
            if (rem > 0)
                rem = rem - 1;
            else if (model_take())
                rem = FC;
        end
    end

    // Compare process: every cycle, away from the rising edge.
    always @(negedge clk) begin
        logic        tk;
        logic        is_irq;
        logic        is_exc;
        logic        is_eret;
        tk      = model_take();
        is_irq  = tk && ev_irq();
        is_exc  = tk && !is_irq && ev_exc();
        is_eret = tk && !is_irq && !is_exc;
        chk("m_hwint",    32'(hwint),    32'(seen_prev));
        chk("m_busy",     32'(busy),     32'(!reset && rem > 0));
        chk("m_flush",    32'(flush),    32'(!reset && (rem > 0 || tk)));
        chk("m_redirect", 32'(redirect), 32'(tk));
        chk("m_exl_set",  32'(exl_set),  32'(is_exc));
        chk("m_exl_clr",  32'(exl_clr),  32'(is_eret));
        chk("m_exc_code", 32'(exc_code), is_exc ? 32'(m_exc_code) : 32'd0);
        chk("m_exc_pc",   exc_pc,        (is_irq || is_exc) ? m_pc : 32'd0);
        chk("m_exc_bd",   32'(exc_bd),   32'((is_irq || is_exc) && m_bd));
        chk("m_redir_pc", redirect_pc,   is_eret ? cp0_epc : HANDLER);
    end

    task automatic clear_m();
        m_valid     = 1'b0;
        m_pc        = 32'd0;
        m_bd        = 1'b0;
        m_exc       = 1'b0;
        m_exc_code  = 5'd0;
        m_eret      = 1'b0;
        cp0_int_req = 1'b0;
        cp0_epc     = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts flush/busy cycles following a take cycle; inputs are idle meanwhile.
    task automatic count_tail(output int fl, output int bz);
        fl = 0;
        bz = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            clear_m();
            #1;
            if (flush) fl++;
            if (busy)  bz++;
        end
    endtask

    initial begin
        int fl;
        int bz;
        int r;
        reset  = 1'b1;
        hw_irq = 6'd0;
        clear_m();
        step();
        step();

        // Reset state and synchronizer latency
        reset  = 1'b0;
        hw_irq = 6'b000100;
        #1;
        chk("rst_hwint",    32'(hwint), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_flush",    32'(flush), 32'd0);
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_exc_pc",   exc_pc, 32'd0);
        chk("rst_redir_pc", redirect_pc, 32'h4180);
        step();
        chk("sync_c1", 32'(hwint), 32'd0);
        step();
        chk("sync_c2", 32'(hwint), 32'b000100);

        // Exception take
        m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd12; m_pc = 32'h3010; m_bd = 1'b1;
        #1;
        chk("exc_exl_set",  32'(exl_set), 32'd1);
        chk("exc_code",     32'(exc_code), 32'd12);
        chk("exc_pc",       exc_pc, 32'h3010);
        chk("exc_bd",       32'(exc_bd), 32'd1);
        chk("exc_redir_pc", redirect_pc, 32'h4180);
        count_tail(fl, bz);
        chk("exc_flush_len", 32'(fl + 1), 32'd3);
        chk("exc_busy_len",  32'(bz), 32'd2);

        // Interrupt together with exception
        step();
        cp0_int_req = 1'b1; m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd10; m_pc = 32'h3020;
        #1;
        chk("ie_exl_set",  32'(exl_set), 32'd0);
        chk("ie_exc_code", 32'(exc_code), 32'd0);
        chk("ie_exc_pc",   exc_pc, 32'h3020);
        chk("ie_redirect", 32'(redirect), 32'd1);
        chk("ie_redir_pc", redirect_pc, 32'h4180);
        count_tail(fl, bz);

        // eret, with an exception pulse during the flush
        clear_m();
        m_valid = 1'b1; m_eret = 1'b1; cp0_epc = 32'h3024;
        #1;
        chk("eret_exl_clr",  32'(exl_clr), 32'd1);
        chk("eret_redir_pc", redirect_pc, 32'h3024);
        step();
        clear_m();
        m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd4;
        #1;
        chk("eret_fl_exl_set",  32'(exl_set), 32'd0);
        chk("eret_fl_redirect", 32'(redirect), 32'd0);
        chk("eret_fl_flush",    32'(flush), 32'd1);
        count_tail(fl, bz);
        chk("eret_flush_tail", 32'(fl), 32'd1);

        // Pending interrupt waits for a valid instruction
        step();
        cp0_int_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("pend_no_take", 32'(redirect), 32'd0);
            step();
            cp0_int_req = 1'b1;
        end
        m_valid = 1'b1; m_pc = 32'h3040;
        #1;
        chk("pend_take", 32'(redirect), 32'd1);
        chk("pend_pc",   exc_pc, 32'h3040);
        count_tail(fl, bz);

        // Reset in the second flush cycle
        m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd5; m_pc = 32'h3050;
        step();
        clear_m();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("rstfl_busy",  32'(busy), 32'd0);
        chk("rstfl_flush", 32'(flush), 32'd0);
        m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd5; m_pc = 32'h3060;
        #1;
        chk("rstfl_retake", 32'(exl_set), 32'd1);
        count_tail(fl, bz);

        // Randomized phase, checked by the compare process
        for (int c = 0; c < 3000; c++) begin
            step();
            r           = int'($urandom_range(0, 99));
            reset       = (r < 2);
            hw_irq      = 6'($urandom);
            m_valid     = ($urandom_range(0, 9) < 7);
            m_exc       = ($urandom_range(0, 4) == 0);
            m_eret      = ($urandom_range(0, 4) == 0);
            cp0_int_req = ($urandom_range(0, 6) == 0);
            m_bd        = 1'($urandom);
            m_pc        = {$urandom_range(0, 32'h0000_ffff), 2'b00};
            cp0_epc     = {$urandom_range(0, 32'h0000_ffff), 2'b00};
            case ($urandom_range(0, 3))
                0:       m_exc_code = 5'd4;
                1:       m_exc_code = 5'd5;
                2:       m_exc_code = 5'd10;
                default: m_exc_code = 5'd12;
            endcase
        end
        step();
        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/exc_sequencer.md
# exc_sequencer

Exception/interrupt sequencer sitting beside CP0 at the M stage. It synchronizes the six raw device interrupt lines into CP0's HWInt input and picks one event per cycle: hardware interrupt, synchronous exception or `eret`. It drives CP0's EXLSet/EXLClr/ExcCode/PC/BD inputs, then runs a fixed-length pipeline flush and a single PC redirect to the handler or to EPC.

## Interface
Parameters
- `HANDLER_ADDR`, 32'h0000_4180, exception/interrupt entry point.
- `FLUSH_CYCLES`, 2, cycles that flush stays asserted after the take cycle; legal range 1..15.

Ports (reset `reset`, synchronous, active-high; clock `clk`)
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `hw_irq` in 6: raw asynchronous device interrupt lines.
- `m_valid` in 1: the M stage holds a real instruction, not a bubble.
- `m_pc` in 32: PC of the M-stage instruction.
- `m_bd` in 1: the M-stage instruction is in a branch delay slot.
- `m_exc` in 1: the M-stage instruction carries an exception.
- `m_exc_code` in 5: ExcCode of that exception (4 AdEL, 5 AdES, 10 RI, 12 Ov).
- `m_eret` in 1: the M-stage instruction is `eret`.
- `cp0_int_req` in 1: CP0 IntReq, already masked by IM/IE/EXL.
- `cp0_epc` in 32: CP0 EPC.
- `hwint` out 6: synchronized interrupt lines to CP0 HWInt.
- `exl_set` out 1: CP0 EXLSet.
- `exl_clr` out 1: CP0 EXLClr.
- `exc_code` out 5: CP0 ExcCode.
- `exc_pc` out 32: CP0 PC input.
- `exc_bd` out 1: CP0 BD input.
- `flush` out 1: kills F/D/E/M pipeline registers this cycle.
- `redirect` out 1: loads `redirect_pc` into the PC this cycle.
- `redirect_pc` out 32: redirect target.
- `busy` out 1: sequencer is in the FLUSH state.

## Operation
**Synchronizer**
- Two flops per line; `hwint` is the second stage.

**States**
- IDLE: evaluates events.
- FLUSH: holds flush and counts down.

**Event selection in IDLE** (all take outputs are combinational in the take cycle)
- Priority 1, interrupt: `cp0_int_req & m_valid`.
  - Outputs: `exc_code`=0, `exc_pc`=`m_pc`, `exc_bd`=`m_bd`, `exl_set`=0. CP0 captures interrupts on IntReq itself.
  - Also `flush`=1, `redirect`=1, `redirect_pc`=`HANDLER_ADDR`.
- Priority 2, exception: `m_valid & m_exc`.
  - Outputs: `exl_set`=1, `exc_code`=`m_exc_code`, `exc_pc`=`m_pc`, `exc_bd`=`m_bd`.
  - Also `flush`=1, `redirect`=1, `redirect_pc`=`HANDLER_ADDR`.
- Priority 3, eret: `m_valid & m_eret & !m_exc`.
  - Outputs: `exl_clr`=1, `flush`=1, `redirect`=1, `redirect_pc`=`cp0_epc`.
- Any take moves to FLUSH and loads the counter with `FLUSH_CYCLES`.

**FLUSH**
- `flush`=1 and `busy`=1.
- All `m_*` inputs and `cp0_int_req` are ignored; `exl_set`, `exl_clr` and `redirect` stay 0.
- The counter decrements each cycle. When it reaches 1, the next state is IDLE.

**Waiting interrupts**
- `cp0_int_req` with `m_valid`=0 is not taken; it stays pending (level) until a valid instruction reaches M.
- An interrupt that arrives during FLUSH is evaluated on the first IDLE cycle.

**Idle output values**
- When no take occurs: `exc_code`=0, `exc_pc`=0, `exc_bd`=0, `redirect_pc`=`HANDLER_ADDR`.

## Timing
**Reset**
- State IDLE, counter 0, synchronizer flops 0.
- Outputs: `hwint`=0, `busy`=0, `flush`=0, `redirect`=0, `exl_set`=0, `exl_clr`=0, `exc_code`=0, `exc_pc`=0, `exc_bd`=0, `redirect_pc`=`HANDLER_ADDR`.
- Reset asserted in a take cycle or mid-FLUSH wins: no take outputs, state returns to IDLE on that edge.

**Latency**
- `hw_irq` to `hwint`: 2 cycles.
- Take outputs: 0 cycles after the qualifying inputs.
- `flush` is high for exactly 1+`FLUSH_CYCLES` consecutive cycles per event.
- `redirect` is high for exactly 1 cycle per event.
- The earliest next take is 1+`FLUSH_CYCLES` cycles after the previous take.

**Simultaneous events**
- Interrupt together with exception: the interrupt is taken and `exl_set`=0. The exception instruction is flushed and re-executes after `eret`.
- Exception together with eret: the exception is taken.

## Test plan
- Reset, then `hw_irq`=6'b000100 at cycle 0 → `hwint`=6'b000100 from cycle 2; all other outputs at reset values.
- Exception: `m_valid`=1, `m_exc`=1, `m_exc_code`=12, `m_pc`=32'h3010, `m_bd`=1 → same cycle `exl_set`=1, `exc_code`=12, `exc_pc`=32'h3010, `exc_bd`=1, `redirect_pc`=32'h4180. `flush` is high for 3 cycles and `busy` for 2 (`FLUSH_CYCLES`=2).
- Interrupt and exception in the same cycle at `m_pc`=32'h3020 → `exl_set`=0, `exc_code`=0, `exc_pc`=32'h3020, `redirect`=1 to 32'h4180.
- `eret` with `cp0_epc`=32'h3024 → `exl_clr`=1, `redirect_pc`=32'h3024, `flush` for 3 cycles; an `m_exc` pulse during FLUSH produces no `exl_set`.
- `cp0_int_req`=1 held with `m_valid`=0 for 3 cycles, then `m_valid`=1 → no take for 3 cycles, take on the 4th.
- Reset asserted in the second FLUSH cycle → next cycle `busy`=0, `flush`=0; a new exception is taken immediately afterwards.
